// File: rtl/effect_pkg.sv
// Shared types and helpers for the effect-chain stages.
// Holds the sequencer state encoding, the level field width and a width-generic saturating add.
package effect_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        MIX
    } state_t;

    localparam int LEVEL_W = 3;

    // Adds two values and clamps the sum to the signed range of 'width' bits.
    function automatic longint sat_add(input longint a, input longint b, input int unsigned width);
        longint sum;
        longint hi;
        longint lo;
        sum = a + b;
        hi  = (longint'(1) <<< (width - 1)) - 1;
        lo  = -(longint'(1) <<< (width - 1));
        if (sum > hi) return hi;
        if (sum < lo) return lo;
        return sum;
    endfunction

endpackage

// File: rtl/effect_sat_mix.sv
// Mixer: dry + sum of taps, tap k arithmetically shifted right by SHIFT_BASE+k, saturated to DATA_W.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module effect_sat_mix
    import effect_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_TAPS   = 2,
    parameter int SHIFT_BASE = 1
) (
    input  logic [DATA_W-1:0]               dry,
    input  logic [NUM_TAPS-1:0][DATA_W-1:0] taps,
    output logic [DATA_W-1:0]               mix
);

    // Headroom for the dry sample plus NUM_TAPS attenuated taps without wrapping.
    localparam int ACC_W = DATA_W + $clog2(NUM_TAPS) + 2;

    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] shifted;

    always_comb begin
        shifted = '0;
        acc     = {{(ACC_W-DATA_W){dry[DATA_W-1]}}, dry};
        for (int k = 0; k < NUM_TAPS; k++) begin
            shifted = $signed(taps[k]) >>> (SHIFT_BASE + k);
            acc     = acc + {{(ACC_W-DATA_W){shifted[DATA_W-1]}}, shifted};
        end
    end

    assign mix = DATA_W'(sat_add(longint'(acc), 64'sd0, DATA_W));

endmodule

// File: rtl/effect_delay_multitap.sv
// Multi-tap SRAM echo: per sample reads NUM_TAPS delayed taps, writes the new sample, emits dry+wet mix.
// Latency: i_valid -> o_valid NUM_TAPS+3 cycles; one sample in flight at a time.
// Backpressure: none; i_valid while busy is dropped and flagged on sticky o_overrun. DELAY_FEEDBACK_EN adds tap-0 feedback.
module effect_delay_multitap
    import effect_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 20,
    parameter int NUM_TAPS = 2,
    parameter int TAP_STEP = 4096,
    parameter int FB_SHIFT = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic               i_enable,
    input  logic [LEVEL_W-1:0] i_level,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [DATA_W-1:0]  i_sram_rdata,
    output logic [ADDR_W-1:0]  o_sram_addr,
    output logic               o_sram_we_n,
    output logic [DATA_W-1:0]  o_sram_wdata,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_valid,
    output logic               o_overrun
);

    localparam int TAP_IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [ADDR_W-1:0] FILL_MAX = '1;

`ifdef DELAY_FEEDBACK_EN
    localparam bit FB_ON = 1'b1;
`else
    localparam bit FB_ON = 1'b0;
`endif

    state_t                          state;
    logic [TAP_IDX_W-1:0]            tap_idx;
    logic [ADDR_W-1:0]               wr_ptr;
    logic [ADDR_W-1:0]               fill;
    logic [DATA_W-1:0]               dry;
    logic                            en_l;
    logic [LEVEL_W-1:0]              level_l;
    logic [NUM_TAPS-1:0][DATA_W-1:0] taps;

    logic [31:0]       tap_dly;
    logic [ADDR_W-1:0] rd_addr;
    logic              tap_filled;
    logic [DATA_W-1:0] mix_dat;
    logic [DATA_W-1:0] fb_dat;
    logic [DATA_W-1:0] wr_dat;

    // Delay of the tap currently being read; the parameter constraint keeps it below 2**ADDR_W.
    always_comb begin
        tap_dly = (32'(level_l) + 32'd1) * 32'(TAP_STEP) * (32'(tap_idx) + 32'd1);
    end

    assign rd_addr    = wr_ptr - tap_dly[ADDR_W-1:0];
    assign tap_filled = 32'(fill) >= tap_dly;

    effect_sat_mix #(
        .DATA_W    (DATA_W),
        .NUM_TAPS  (NUM_TAPS),
        .SHIFT_BASE(1)
    ) u_mix (
        .dry (dry),
        .taps(taps),
        .mix (mix_dat)
    );

    effect_sat_mix #(
        .DATA_W    (DATA_W),
        .NUM_TAPS  (1),
        .SHIFT_BASE(FB_SHIFT)
    ) u_fb (
        .dry (dry),
        .taps(taps[0]),
        .mix (fb_dat)
    );

    // Bypass still writes the dry sample so the history is current when the effect is re-enabled.
    assign wr_dat = (FB_ON && en_l) ? fb_dat : dry;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            tap_idx   <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            dry       <= '0;
            en_l      <= 1'b0;
            level_l   <= '0;
            taps      <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_valid && state != IDLE) o_overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        dry     <= i_data;
                        en_l    <= i_enable;
                        level_l <= i_level;
                        tap_idx <= '0;
                        state   <= READ;
                    end
                end
                READ: begin
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        if (tap_idx == TAP_IDX_W'(k)) taps[k] <= tap_filled ? i_sram_rdata : '0;
                    end
                    if (tap_idx == TAP_IDX_W'(NUM_TAPS - 1)) state <= WRITE;
                    else tap_idx <= tap_idx + 1'b1;
                end
                WRITE: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (fill != FILL_MAX) fill <= fill + 1'b1;
                    state <= MIX;
                end
                MIX: begin
                    o_data  <= en_l ? mix_dat : dry;
                    o_valid <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Async SRAM: address and strobe decode straight from state so reads land in the same cycle.
    always_comb begin
        o_sram_addr  = '0;
        o_sram_we_n  = 1'b1;
        o_sram_wdata = '0;
        case (state)
            READ:  o_sram_addr = rd_addr;
            WRITE: begin
                o_sram_addr  = wr_ptr;
                o_sram_we_n  = 1'b0;
                o_sram_wdata = wr_dat;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_effect_delay_multitap.sv
// Bench for effect_delay_multitap: async SRAM model, reference history model and output/write scoreboards.
module tb_effect_delay_multitap;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 12;
    localparam int NUM_TAPS = 2;
    localparam int TAP_STEP = 64;
    localparam int FB_SHIFT = 2;
    localparam int DEPTH    = 1 << ADDR_W;

`ifdef DELAY_FEEDBACK_EN
    localparam bit FB_ON = 1'b1;
`else
    localparam bit FB_ON = 1'b0;
`endif

    logic              clk;
    logic              i_rst;
    logic              i_valid;
    logic              i_enable;
    logic [2:0]        i_level;
    logic [DATA_W-1:0] i_data;
    logic [DATA_W-1:0] i_sram_rdata;
    logic [ADDR_W-1:0] o_sram_addr;
    logic              o_sram_we_n;
    logic [DATA_W-1:0] o_sram_wdata;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_overrun;

    effect_delay_multitap #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_TAPS(NUM_TAPS),
        .TAP_STEP(TAP_STEP),
        .FB_SHIFT(FB_SHIFT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_enable    (i_enable),
        .i_level     (i_level),
        .i_data      (i_data),
        .i_sram_rdata(i_sram_rdata),
        .o_sram_addr (o_sram_addr),
        .o_sram_we_n (o_sram_we_n),
        .o_sram_wdata(o_sram_wdata),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_overrun   (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] sram [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) sram[i] <= 16'h5a5a;
    end
    assign i_sram_rdata = sram[o_sram_addr];
    always @(posedge clk) if (!o_sram_we_n) sram[o_sram_addr] <= o_sram_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    int m_mem [DEPTH];
    int m_wr   = 0;
    int m_fill = 0;
    int exp_out_q [$];
    int exp_wr_q  [$];

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    always @(negedge clk) begin
        if (o_valid) begin
            if (exp_out_q.size() == 0) check("o_valid_unexpected", o_valid, 0);
            else check("o_data", $signed(o_data), exp_out_q.pop_front());
        end
        if (!o_sram_we_n) begin
            if (exp_wr_q.size() == 0) check("we_n_unexpected", o_sram_we_n, 1);
            else check("sram_write", longint'({o_sram_addr, o_sram_wdata}), exp_wr_q.pop_front());
        end
    end

    task automatic send(input int d, input bit en, input int lvl, input bit glitch, output int got);
        int tap [NUM_TAPS];
        int rda [NUM_TAPS];
        int dly;
        int wv;
        int ov;
        int lat;
        for (int k = 0; k < NUM_TAPS; k++) begin
            dly    = (lvl + 1) * TAP_STEP * (k + 1);
            rda[k] = (m_wr - dly + DEPTH) % DEPTH;
            tap[k] = (m_fill >= dly) ? m_mem[rda[k]] : 0;
        end
        wv = (FB_ON && en) ? clamp16(d + (tap[0] >>> FB_SHIFT)) : d;
        ov = d;
        if (en) begin
            for (int k = 0; k < NUM_TAPS; k++) ov = ov + (tap[k] >>> (k + 1));
            ov = clamp16(ov);
        end
        exp_wr_q.push_back(m_wr * 65536 + (wv & 16'hffff));
        exp_out_q.push_back(ov);
        m_mem[m_wr] = wv;
        m_wr = (m_wr + 1) % DEPTH;
        if (m_fill < DEPTH - 1) m_fill++;

        @(negedge clk);
        i_valid  = 1'b1;
        i_data   = 16'(d);
        i_enable = en;
        i_level  = 3'(lvl);
        lat = 0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            @(negedge clk);
            lat++;
            if (k == 0) begin
                i_valid  = 1'b0;
                i_data   = 16'($urandom);
                i_enable = 1'($urandom);
                i_level  = 3'($urandom);
            end
            check("rd_addr", o_sram_addr, rda[k]);
            if (glitch && k == 0) i_valid = 1'b1;
            if (glitch && k == 1) i_valid = 1'b0;
        end
        while (!o_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, NUM_TAPS + 3);
        got = $signed(o_data);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst   = 1'b1;
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
        i_rst  = 1'b0;
        m_wr   = 0;
        m_fill = 0;
        exp_out_q.delete();
        exp_wr_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int d;
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_enable = 1'b0;
        i_level  = '0;
        i_data   = '0;
        repeat (3) @(negedge clk);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_overrun", o_overrun, 0);
        check("rst_we_n", o_sram_we_n, 1);
        check("rst_addr", o_sram_addr, 0);
        check("rst_wdata", o_sram_wdata, 0);
        i_rst = 1'b0;

        // First sample after reset: unfilled taps contribute nothing.
        send(1000, 1'b1, 0, 1'b0, got);
        check("first_out", got, 1000);
        check("sram0", sram[0], 1000);

        // Impulse response at level 0: echoes at 64 and 128 samples.
        do_reset();
        send(16000, 1'b1, 0, 1'b0, got);
        for (int i = 1; i <= 140; i++) begin
            send(0, 1'b1, 0, 1'b0, got);
            if (i == 64) check("echo_d1", got, 8000);
            if (i == 128) check("echo_d2", got, FB_ON ? 6000 : 4000);
        end

        // Saturation at both rails.
        repeat (200) send(32767, 1'b1, 0, 1'b0, got);
        check("sat_pos", got, 32767);
        repeat (200) send(-32768, 1'b1, 0, 1'b0, got);
        check("sat_neg", got, -32768);

        // Bypass with full history.
        for (int i = 0; i < 20; i++) begin
            d = $urandom_range(0, 65535) - 32768;
            send(d, 1'b0, $urandom_range(0, 7), 1'b0, got);
            check("bypass_out", got, d);
        end

        // Overrun while busy is sticky and leaves the in-flight sample intact.
        check("overrun_pre", o_overrun, 0);
        send(1234, 1'b1, 2, 1'b1, got);
        check("overrun_set", o_overrun, 1);
        repeat (3) send($urandom_range(0, 2000), 1'b1, 1, 1'b0, got);
        check("overrun_sticky", o_overrun, 1);

        // Long random run across the pointer wrap.
        do_reset();
        check("overrun_cleared", o_overrun, 0);
        for (int i = 0; i < 4200; i++) begin
            d = $urandom_range(0, 24000) - 12000;
            send(d, ($urandom_range(0, 9) != 0), $urandom_range(0, 7), 1'b0, got);
        end

        // Reset in the middle of a READ.
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = 16'd555;
        i_enable = 1'b1;
        i_level = 3'd0;
        @(negedge clk);
        i_valid = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        check("we_n_rst_read", o_sram_we_n, 1);
        check("addr_rst_read", o_sram_addr, 0);
        repeat (2) @(negedge clk);
        i_rst  = 1'b0;
        m_wr   = 0;
        m_fill = 0;
        exp_out_q.delete();
        exp_wr_q.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_valid_after_rst_read", o_valid, 0);
        end

        // Reset in the middle of a WRITE releases the write strobe asynchronously.
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = 16'd777;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (NUM_TAPS) @(posedge clk);
        #2;
        check("we_n_in_write", o_sram_we_n, 0);
        i_rst = 1'b1;
        #1;
        check("we_n_rst_write", o_sram_we_n, 1);
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_valid_after_rst_write", o_valid, 0);
        end

        // History and write pointer restart from zero.
        send(4321, 1'b1, 0, 1'b0, got);
        check("post_rst_out", got, 4321);
        check("post_rst_sram0", sram[0], 4321);

        repeat (4) @(negedge clk);
        check("out_q_drained", exp_out_q.size(), 0);
        check("wr_q_drained", exp_wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
